microcode_sequencer: RTL

- Drives the 7-bit address of the microcode ROM as {opcode[3:0], step[2:0]} and gates the 18-bit microword it returns into the machine's live control word.
- Owns the T-state step counter, fetch/execute sequencing, early return to fetch on empty steps, HLT latching, illegal-opcode trapping, run/single-step control and a retired-instruction counter.
- Sits between the instruction register and the microcode ROM. All datapath load/enable lines are taken from CTRL.

---
 rtl/sap_ctrl_pkg.sv | 42 ++++
 rtl/microcode_sequencer_step_counter.sv | 28 ++
 rtl/microcode_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP control path: control-word bit map,
// opcode encodings, default illegal-opcode mask and sequencer state type.
package sap_ctrl_pkg;

  localparam int unsigned STEP_W = 3;
  localparam int unsigned CW_W   = 18;

  // Control-word bit indices
  localparam int unsigned CB_HLT = 17;
  localparam int unsigned CB_MI  = 16;
  localparam int unsigned CB_RI  = 15;
  localparam int unsigned CB_RO  = 14;
  localparam int unsigned CB_IO  = 13;
  localparam int unsigned CB_II  = 12;
  localparam int unsigned CB_AI  = 11;
  localparam int unsigned CB_AO  = 10;
  localparam int unsigned CB_EO  = 9;
  localparam int unsigned CB_SU  = 8;
  localparam int unsigned CB_BI  = 7;
  localparam int unsigned CB_OI  = 6;
  localparam int unsigned CB_CE  = 5;
  localparam int unsigned CB_CO  = 4;
  localparam int unsigned CB_J   = 3;
  localparam int unsigned CB_FI  = 2;
  localparam int unsigned CB_JC  = 1;
  localparam int unsigned CB_JZ  = 0;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Opcodes 1011, 1100 and 1101 are unassigned and trap
  localparam logic [15:0] DEF_ILLEGAL_MASK = 16'h3800;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/microcode_sequencer_step_counter.sv
// T-state counter: advances on enable, returns to 0 on clear, freezes on hold.
import sap_ctrl_pkg::*;

module step_counter #(
  parameter int unsigned STEP_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic              i_hold,
  output logic [STEP_W-1:0] o_step
);

  logic [STEP_W-1:0] r_step;

  // Step register; hold wins over clear, clear wins over increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step <= '0;
    end else if (i_en && !i_hold) begin
      r_step <= i_clr ? '0 : r_step + 1'b1;
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: drives the ROM address from {opcode, step}, gates the
// returned microword onto CTRL, and handles early end, halt, illegal-opcode
// traps, run/single-step control and retired-instruction counting.
import sap_ctrl_pkg::*;

module microcode_sequencer #(
  parameter int unsigned NUM_STEPS    = 5,
  parameter int unsigned FETCH_STEPS  = 2,
  parameter int unsigned HLT_BIT      = 17,
  parameter logic [15:0] ILLEGAL_MASK = DEF_ILLEGAL_MASK,
  parameter int unsigned ICNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RUN,
  input  logic              STEP_REQ,
  input  logic [3:0]        IR_OPCODE,
  input  logic [CW_W-1:0]   EEPROM_OUT,
  output logic [6:0]        Address,
  output logic [CW_W-1:0]   CTRL,
  output logic [STEP_W-1:0] STEP,
  output logic              FETCH,
  output logic              HALTED,
  output logic              ILLEGAL,
  output logic [ICNT_W-1:0] ICNT
);

  localparam logic [STEP_W-1:0] LP_FETCH = STEP_W'(FETCH_STEPS);
  localparam logic [STEP_W-1:0] LP_LAST  = STEP_W'(NUM_STEPS - 1);

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [ICNT_W-1:0] r_icnt;
  logic [STEP_W-1:0] w_step;
  logic              w_adv;
  logic              w_exec;
  logic              w_illegal;
  logic              w_hlt;
  logic              w_empty;
  logic              w_last;
  logic              w_retire;
  logic              w_clr;

  // Holding RST_N low also blocks advance so CTRL reads 0 throughout reset
  assign w_adv  = RST_N && (r_state == S_RUN) && (RUN || STEP_REQ);
  assign w_exec = (w_step >= LP_FETCH);
  assign w_last = (w_step == LP_LAST);

  // Trap decode uses only the opcode, so unknown ROM data cannot leak
  assign w_illegal = w_adv && w_exec && ILLEGAL_MASK[IR_OPCODE];
  assign w_hlt     = w_adv && w_exec && !w_illegal && EEPROM_OUT[HLT_BIT];
  assign w_empty   = w_exec && (EEPROM_OUT == '0);
  assign w_retire  = w_adv && !w_illegal && !w_hlt && (w_empty || w_last);
  assign w_clr     = w_illegal || w_retire;

  step_counter #(
    .STEP_W(STEP_W)
  ) u_step (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_en    (w_adv),
    .i_clr   (w_clr),
    .i_hold  (w_hlt),
    .o_step  (w_step)
  );

  // Run/halt state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Halt is entered on a halting microword and left only by reset
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == S_RUN) && w_hlt) begin
      w_state_nxt = S_HALT;
    end
  end

  // Retired-instruction counter, saturating at all-ones
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_icnt <= '0;
    end else if (w_retire && (r_icnt != '1)) begin
      r_icnt <= r_icnt + 1'b1;
    end
  end

  assign Address = {IR_OPCODE, w_step};
  assign CTRL    = (w_adv && !w_illegal) ? EEPROM_OUT : '0;
  assign STEP    = w_step;
  assign FETCH   = (w_step < LP_FETCH);
  assign HALTED  = (r_state == S_HALT);
  assign ILLEGAL = w_illegal;
  assign ICNT    = r_icnt;

endmodule
